// File: rtl/hazard_forward_ctrl_if.sv
// Decode-stage hazard bus between the MIPS pipeline and hazard_forward_ctrl.
// The pipeline (master) presents the D-stage instruction fields and receives the
// EX operand-mux selects plus the load-use stall/flush controls.
// Optional feature macro: HAZARD_STALL_CNT_EN adds the stall_count signal.
interface hazard_forward_ctrl_if #(
  parameter int REG_AW = 5
`ifdef HAZARD_STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_we;
  logic              id_is_load;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              stall_fd;
  logic              flush_e;
`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_count;
`endif

  modport master (
    output id_valid, output id_rs, output id_rt, output id_use_rs, output id_use_rt,
    output id_dst, output id_we, output id_is_load,
    input  ForwardAE, input ForwardBE, input stall_fd, input flush_e
`ifdef HAZARD_STALL_CNT_EN
    , input stall_count
`endif
  );

  modport slave (
    input  id_valid, input id_rs, input id_rt, input id_use_rs, input id_use_rt,
    input  id_dst, input id_we, input id_is_load,
    output ForwardAE, output ForwardBE, output stall_fd, output flush_e
`ifdef HAZARD_STALL_CNT_EN
    , output stall_count
`endif
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Hazard unit for a 5-stage MIPS pipeline: keeps shadow copies of the E/M/W
// hazard info, produces EX operand forwarding selects (00 regfile, 01 W, 10 M)
// and the single-cycle load-use stall/flush.
// Optional feature macro: HAZARD_STALL_CNT_EN adds a saturating stall counter.
module hazard_forward_ctrl #(
  parameter int REG_AW = 5
`ifdef HAZARD_STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_forward_ctrl_if.slave  hz
);

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  // E stage shadow (control fields are reset, register numbers are not)
  logic              e_valid_q, e_valid_d;
  logic              e_use_rs_q, e_use_rs_d;
  logic              e_use_rt_q, e_use_rt_d;
  logic              e_we_q, e_we_d;
  logic              e_load_q, e_load_d;
  logic [REG_AW-1:0] e_rs_q, e_rt_q, e_dst_q;
  // M and W stage shadows
  logic              m_valid_q, m_we_q, w_valid_q, w_we_q;
  logic [REG_AW-1:0] m_dst_q, w_dst_q;

  logic e_wr, m_wr, w_wr, take_d, stall;

  // Forward select for one EX operand; M beats W, $0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic              e_valid,
    input logic              e_use,
    input logic [REG_AW-1:0] src,
    input logic              m_wr_f,
    input logic [REG_AW-1:0] m_dst,
    input logic              w_wr_f,
    input logic [REG_AW-1:0] w_dst
  );
    logic need;
    need = e_valid & e_use & (src != ZERO_REG);
    if (need && m_wr_f && (m_dst == src))      fwd_sel = 2'b10;
    else if (need && w_wr_f && (w_dst == src)) fwd_sel = 2'b01;
    else                                       fwd_sel = 2'b00;
  endfunction

  // Effective writes, load-use detection and next E-stage control
  always_comb begin
    e_wr  = e_valid_q & e_we_q & (e_dst_q != ZERO_REG);
    m_wr  = m_valid_q & m_we_q & (m_dst_q != ZERO_REG);
    w_wr  = w_valid_q & w_we_q & (w_dst_q != ZERO_REG);
    stall = hz.id_valid & e_wr & e_load_q &
            ((hz.id_use_rs & (hz.id_rs == e_dst_q)) |
             (hz.id_use_rt & (hz.id_rt == e_dst_q)));
    take_d     = hz.id_valid & ~stall;
    e_valid_d  = take_d;
    e_use_rs_d = take_d & hz.id_use_rs;
    e_use_rt_d = take_d & hz.id_use_rt;
    e_we_d     = take_d & hz.id_we;
    e_load_d   = take_d & hz.id_is_load;
  end

  assign hz.stall_fd  = stall;
  assign hz.flush_e   = stall;
  assign hz.ForwardAE = fwd_sel(e_valid_q, e_use_rs_q, e_rs_q, m_wr, m_dst_q, w_wr, w_dst_q);
  assign hz.ForwardBE = fwd_sel(e_valid_q, e_use_rt_q, e_rt_q, m_wr, m_dst_q, w_wr, w_dst_q);

  // D->E, E->M, M->W control shadow advance (cleared by reset)
  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid_q  <= 1'b0;
      e_use_rs_q <= 1'b0;
      e_use_rt_q <= 1'b0;
      e_we_q     <= 1'b0;
      e_load_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      m_we_q     <= 1'b0;
      w_valid_q  <= 1'b0;
      w_we_q     <= 1'b0;
    end else begin
      e_valid_q  <= e_valid_d;
      e_use_rs_q <= e_use_rs_d;
      e_use_rt_q <= e_use_rt_d;
      e_we_q     <= e_we_d;
      e_load_q   <= e_load_d;
      m_valid_q  <= e_valid_q;
      m_we_q     <= e_we_q;
      w_valid_q  <= m_valid_q;
      w_we_q     <= m_we_q;
    end
  end

  // Register-number shadow advance; meaningless unless the matching valid is set
  always_ff @(posedge clk) begin
    e_rs_q  <= hz.id_rs;
    e_rt_q  <= hz.id_rt;
    e_dst_q <= hz.id_dst;
    m_dst_q <= e_dst_q;
    w_dst_q <= m_dst_q;
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating stall-cycle count
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign hz.stall_count = cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: instruction sequences driven into D,
// forwarding selects and stall controls checked mid-cycle against hand values.
module tb_hazard_forward_ctrl;
  localparam int REG_AW = 5;
`ifdef HAZARD_STALL_CNT_EN
  localparam int CNT_W = 16;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

`ifdef HAZARD_STALL_CNT_EN
  hazard_forward_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();
  hazard_forward_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .hz(hz));
`else
  hazard_forward_ctrl_if #(.REG_AW(REG_AW)) hz ();
  hazard_forward_ctrl #(.REG_AW(REG_AW)) dut (.clk(clk), .reset(reset), .hz(hz));
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one D-stage instruction
  task automatic drv(input logic v, input int rs, input int rt, input logic urs,
                     input logic urt, input int dst, input logic we, input logic ld);
    hz.id_valid   = v;
    hz.id_rs      = REG_AW'(rs);
    hz.id_rt      = REG_AW'(rt);
    hz.id_use_rs  = urs;
    hz.id_use_rt  = urt;
    hz.id_dst     = REG_AW'(dst);
    hz.id_we      = we;
    hz.id_is_load = ld;
  endtask

  task automatic nop();
    drv(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic drv_rand();
    drv(1'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
        1'($urandom), 1'($urandom), int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
  endtask

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
    chk({tag, "_FAE"}, 32'(hz.ForwardAE), 32'(a));
    chk({tag, "_FBE"}, 32'(hz.ForwardBE), 32'(b));
  endtask

  task automatic chk_stall(input string tag, input logic s);
    chk({tag, "_stall"}, 32'(hz.stall_fd), 32'(s));
    chk({tag, "_flush"}, 32'(hz.flush_e), 32'(s));
  endtask

  task automatic chk_cnt(input string tag, input int n);
`ifdef HAZARD_STALL_CNT_EN
    chk({tag, "_cnt"}, 32'(hz.stall_count), 32'(n));
`else
    if (n < 0) $display("unused %s", tag);
`endif
  endtask

  initial begin
    // 1: reset with random D inputs
    reset = 1'b1;
    drv_rand();
    tick();
    drv_rand();
    tick();
    reset = 1'b0;
    nop();
    #1;
    chk_fwd("rst", 2'b00, 2'b00);
    chk_stall("rst", 1'b0);
    chk_cnt("rst", 0);

    // 2: addu $3,$1,$2 ; subu $4,$3,$5 -> M forward on A
    drv(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    tick();
    drv(1'b1, 3, 5, 1'b1, 1'b1, 4, 1'b1, 1'b0);
    #1;
    chk_stall("t2d", 1'b0);
    tick();
    nop();
    #1;
    chk_fwd("t2", 2'b10, 2'b00);
    chk_stall("t2", 1'b0);
    tick(); tick(); tick();

    // 3: addu $3 ; bubble ; or $6,$7,$3 -> W forward on B
    drv(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    drv(1'b1, 7, 3, 1'b1, 1'b1, 6, 1'b1, 1'b0);
    tick();
    nop();
    #1;
    chk_fwd("t3", 2'b00, 2'b01);
    tick(); tick(); tick();

    // 4: lw $3,0($1) ; addu $4,$3,$3 -> one stall cycle then W forward on both
    drv(1'b1, 1, 0, 1'b1, 1'b0, 3, 1'b1, 1'b1);
    tick();
    drv(1'b1, 3, 3, 1'b1, 1'b1, 4, 1'b1, 1'b0);
    #1;
    chk_stall("t4s", 1'b1);
    tick();
    chk_stall("t4r", 1'b0);
    chk_fwd("t4b", 2'b00, 2'b00);
    tick();
    nop();
    #1;
    chk_fwd("t4", 2'b01, 2'b01);
    chk_stall("t4", 1'b0);
    chk_cnt("t4", 1);
    tick(); tick(); tick();

    // 5: writes to $0 never forward or stall
    drv(1'b1, 1, 2, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    tick();
    drv(1'b1, 1, 0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
    tick();
    drv(1'b1, 0, 0, 1'b1, 1'b1, 5, 1'b1, 1'b0);
    #1;
    chk_stall("t5s", 1'b0);
    tick();
    nop();
    #1;
    chk_fwd("t5", 2'b00, 2'b00);
    tick(); tick(); tick();

    // 6: addu $3 ; addu $3 ; subu $6,$3,$3 -> M beats W on both
    drv(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    tick();
    drv(1'b1, 4, 5, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    tick();
    drv(1'b1, 3, 3, 1'b1, 1'b1, 6, 1'b1, 1'b0);
    tick();
    nop();
    #1;
    chk_fwd("t6", 2'b10, 2'b10);
    tick(); tick(); tick();

    // 7: only operands actually read are forwarded
    drv(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    tick();
    drv(1'b1, 3, 3, 1'b1, 1'b0, 8, 1'b1, 1'b0);
    tick();
    nop();
    #1;
    chk_fwd("t7", 2'b10, 2'b00);
    tick(); tick(); tick();

    // 8: bubble in D behind a load cannot stall, even with matching fields
    drv(1'b1, 1, 0, 1'b1, 1'b0, 3, 1'b1, 1'b1);
    tick();
    drv(1'b0, 3, 3, 1'b1, 1'b1, 3, 1'b1, 1'b1);
    #1;
    chk_stall("t8", 1'b0);
    tick(); tick(); tick();
    chk_cnt("t8", 1);

    // 9: reset during a load-use stall discards it
    drv(1'b1, 1, 0, 1'b1, 1'b0, 3, 1'b1, 1'b1);
    tick();
    drv(1'b1, 3, 0, 1'b1, 1'b0, 4, 1'b1, 1'b0);
    #1;
    chk_stall("t9s", 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk_stall("t9r", 1'b0);
    chk_fwd("t9r", 2'b00, 2'b00);
    chk_cnt("t9r", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
